// File: rtl/score_digits_gu.sv
// Draws a binary score as a row of decimal sprite glyphs on the VGA pixel-write port.
// Double-dabble converts the score to BCD, then each digit is drawn from an external 1-cycle glyph ROM.
module score_digits_gu #(
   parameter int DIGITS      = 3,
   parameter int SCORE_W     = 10,
   parameter int SPR_WB      = 5,
   parameter int SPR_HB      = 5,
   parameter int GAP         = 2,
   parameter int Y_OFFSET    = 10,
   parameter int SCR_W       = 320,
   parameter int SCR_H       = 240,
   parameter int TRANSPARENT = 0
) (
   input  logic                        clk,
   input  logic                        resetn,
   input  logic                        plot,
   input  logic [SCORE_W-1:0]          score,
   input  logic [8:0]                  x_in,
   input  logic [7:0]                  y_in,
   input  logic                        game_over,
   input  logic                        blank_lz,
   output logic [3+SPR_HB+SPR_WB:0]    rom_addr,
   input  logic [2:0]                  rom_data,
   output logic [8:0]                  x_out,
   output logic [7:0]                  y_out,
   output logic [2:0]                  colour_out,
   output logic                        writeEn,
   output logic                        busy,
   output logic                        done
);

   localparam int              SPR_W   = 2 ** SPR_WB;
   localparam int              BW      = 4 * DIGITS;
   localparam int              PW      = SPR_WB + SPR_HB;
   localparam int              CW      = $clog2(SCORE_W) + 1;
   localparam logic [9:0]      STEP    = 10'(SPR_W + GAP);
   localparam logic [31:0]     POW10   = 32'(10 ** DIGITS);
   localparam logic [9:0]      SCR_W_L = 10'(SCR_W);
   localparam logic [8:0]      SCR_H_L = 9'(SCR_H);
   localparam logic [7:0]      Y_OFF   = 8'(Y_OFFSET);
   localparam logic [BW-1:0]   ALL9    = {DIGITS{4'h9}};
   localparam logic [2:0]      LAST_K  = 3'(DIGITS - 1);
   localparam logic [2:0]      END_K   = 3'(DIGITS);

   typedef enum logic [2:0] {IDLE, CONV, NEXT_DIG, PIX_A, PIX_W, DONE} state_t;

   state_t               state, state_nxt;
   logic [SCORE_W-1:0]   bin_sr;
   logic [BW-1:0]        bcd_sr;
   logic [CW-1:0]        conv_cnt;
   logic                 ovf;
   logic [2:0]           dig_k;
   logic                 seen_nz;
   logic [9:0]           slot_x;
   logic [9:0]           draw_x;
   logic [7:0]           y_base;
   logic                 go_r;
   logic                 blz_r;
   logic [PW-1:0]        pix_cnt;
   logic [SPR_WB-1:0]    px_r;
   logic [SPR_HB-1:0]    py_r;
   logic [3:0]           cur_digit;

   logic [3:0]           top_digit;
   logic                 skip_dig;
   logic                 conv_last;
   logic                 pix_last;
   logic [9:0]           x_full;
   logic [8:0]           y_full;
   logic                 clipped;

   // One double-dabble iteration: add 3 to every nibble >= 5, then shift in the next score bit
   function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] b, input logic bit_in);
      logic [BW-1:0] a;
      a = b;
      for (int i = 0; i < DIGITS; i++) begin
         if (a[4*i +: 4] >= 4'd5)
            a[4*i +: 4] = a[4*i +: 4] + 4'd3;
      end
      return {a[BW-2:0], bit_in};
   endfunction

   assign top_digit = bcd_sr[BW-1 -: 4];
   assign skip_dig  = blz_r && (top_digit == 4'd0) && !seen_nz && (dig_k != LAST_K);
   assign conv_last = (conv_cnt == CW'(SCORE_W - 1));
   assign pix_last  = &{py_r, px_r};
   assign x_full    = draw_x + 10'(px_r);
   assign y_full    = {1'b0, y_base} + 9'(py_r);
   assign clipped   = (x_full >= SCR_W_L) || (y_full >= SCR_H_L);

   always_ff @(posedge clk) begin
      if (!resetn)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Next-state and pixel-port outputs; every output is zero outside the state that owns it
   always_comb begin
      state_nxt  = state;
      rom_addr   = '0;
      x_out      = '0;
      y_out      = '0;
      colour_out = '0;
      writeEn    = 1'b0;
      busy       = (state != IDLE);
      done       = 1'b0;
      case (state)
         IDLE:     if (plot) state_nxt = CONV;
         CONV:     if (conv_last) state_nxt = NEXT_DIG;
         NEXT_DIG: begin
            if (skip_dig)
               state_nxt = (dig_k == LAST_K) ? DONE : NEXT_DIG;
            else
               state_nxt = PIX_A;
         end
         PIX_A: begin
            rom_addr  = {cur_digit, pix_cnt};
            state_nxt = PIX_W;
         end
         PIX_W: begin
            x_out      = x_full[8:0];
            y_out      = y_full[7:0];
            colour_out = go_r ? ~rom_data : rom_data;
            writeEn    = !clipped && !((TRANSPARENT != 0) && (rom_data == 3'b000));
            if (pix_last)
               state_nxt = (dig_k == END_K) ? DONE : NEXT_DIG;
            else
               state_nxt = PIX_A;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default:  state_nxt = IDLE;
      endcase
   end

   // Datapath: request latch, BCD conversion, digit walk and pixel counter
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bin_sr    <= '0;
         bcd_sr    <= '0;
         conv_cnt  <= '0;
         ovf       <= 1'b0;
         dig_k     <= '0;
         seen_nz   <= 1'b0;
         slot_x    <= '0;
         draw_x    <= '0;
         y_base    <= '0;
         go_r      <= 1'b0;
         blz_r     <= 1'b0;
         pix_cnt   <= '0;
         px_r      <= '0;
         py_r      <= '0;
         cur_digit <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (plot) begin
                  bin_sr   <= score;
                  bcd_sr   <= '0;
                  conv_cnt <= '0;
                  ovf      <= (32'(score) >= POW10);
                  dig_k    <= '0;
                  seen_nz  <= 1'b0;
                  slot_x   <= {1'b0, x_in};
                  y_base   <= y_in + Y_OFF;
                  go_r     <= game_over;
                  blz_r    <= blank_lz;
               end
            end
            CONV: begin
               bin_sr   <= bin_sr << 1;
               conv_cnt <= conv_cnt + 1'b1;
               bcd_sr   <= (conv_last && ovf) ? ALL9 : dd_step(bcd_sr, bin_sr[SCORE_W-1]);
            end
            NEXT_DIG: begin
               bcd_sr    <= bcd_sr << 4;
               cur_digit <= top_digit;
               seen_nz   <= seen_nz | (top_digit != 4'd0);
               draw_x    <= slot_x;
               slot_x    <= slot_x + STEP;
               dig_k     <= dig_k + 3'd1;
               pix_cnt   <= '0;
            end
            PIX_A: begin
               px_r <= pix_cnt[SPR_WB-1:0];
               py_r <= pix_cnt[PW-1:SPR_WB];
            end
            PIX_W:   pix_cnt <= pix_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_score_digits_gu.sv
// Scoreboard bench for score_digits_gu: a reference model queues expected pixel writes per draw,
// the monitor pops them as writeEn fires; a second instance covers the transparent build.
module tb_score_digits_gu;

   localparam int DIGITS  = 3;
   localparam int SCORE_W = 10;
   localparam int SPR_W   = 32;
   localparam int SPR_H   = 32;
   localparam int STEP    = 34;
   localparam int PIXCYC  = 2 * SPR_W * SPR_H;

   typedef struct packed {
      logic [8:0] x;
      logic [7:0] y;
      logic [2:0] c;
   } pix_t;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        plot = 1'b0;
   logic [9:0]  score = '0;
   logic [8:0]  x_in = '0;
   logic [7:0]  y_in = '0;
   logic        game_over = 1'b0;
   logic        blank_lz = 1'b0;

   logic [13:0] rom_addr0, rom_addr1;
   logic [2:0]  rom_data0, rom_data1;
   logic [8:0]  x_out0, x_out1;
   logic [7:0]  y_out0, y_out1;
   logic [2:0]  colour0, colour1;
   logic        we0, we1, busy0, busy1, done0, done1;

   bit          rom_zero = 1'b0;
   int          tests = 0;
   int          fails = 0;
   pix_t        exp_q[$];
   int          dd_exp[4];

   score_digits_gu dut0 (
      .clk(clk), .resetn(resetn), .plot(plot), .score(score), .x_in(x_in), .y_in(y_in),
      .game_over(game_over), .blank_lz(blank_lz), .rom_addr(rom_addr0), .rom_data(rom_data0),
      .x_out(x_out0), .y_out(y_out0), .colour_out(colour0), .writeEn(we0), .busy(busy0), .done(done0)
   );

   score_digits_gu #(.TRANSPARENT(1)) dut1 (
      .clk(clk), .resetn(resetn), .plot(plot), .score(score), .x_in(x_in), .y_in(y_in),
      .game_over(game_over), .blank_lz(blank_lz), .rom_addr(rom_addr1), .rom_data(rom_data1),
      .x_out(x_out1), .y_out(y_out1), .colour_out(colour1), .writeEn(we1), .busy(busy1), .done(done1)
   );

   always #5 clk = ~clk;

   function automatic logic [2:0] rom_fn(input logic [13:0] a);
      if (rom_zero) return 3'b000;
      return a[2:0] + a[7:5] + a[12:10] + {2'b00, a[13]};
   endfunction

   // Glyph ROM with one cycle of read latency, one per instance
   always @(posedge clk) begin
      rom_data0 <= rom_fn(rom_addr0);
      rom_data1 <= rom_fn(rom_addr1);
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: fills exp_q for the opaque build, counts writes of the transparent build
   task automatic buildModel(input int sc, input int xi, input int yi, input bit go, input bit blz,
                             output int ndrawn, output int nw1);
      int   v;
      bit   nz;
      bit   skip;
      int   xx, yy;
      logic [13:0] a;
      logic [2:0]  c;
      pix_t p;
      ndrawn = 0;
      nw1 = 0;
      v = sc;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         dd_exp[k] = v % 10;
         v = v / 10;
      end
      if (sc >= 1000)
         for (int k = 0; k < DIGITS; k++) dd_exp[k] = 9;
      nz = 1'b0;
      for (int k = 0; k < DIGITS; k++) begin
         skip = blz && (dd_exp[k] == 0) && !nz && (k != DIGITS - 1);
         if (dd_exp[k] != 0) nz = 1'b1;
         if (!skip) begin
            ndrawn++;
            for (int py = 0; py < SPR_H; py++)
               for (int px = 0; px < SPR_W; px++) begin
                  a  = 14'(dd_exp[k] * 1024 + py * 32 + px);
                  c  = rom_fn(a);
                  xx = xi + k * STEP + px;
                  yy = ((yi + 10) % 256) + py;
                  if (xx < 320 && yy < 240) begin
                     p.x = 9'(xx);
                     p.y = 8'(yy);
                     p.c = go ? ~c : c;
                     exp_q.push_back(p);
                     if (c != 3'b000) nw1++;
                  end
               end
         end
      end
   endtask

   task automatic applyStimulus(input int sc, input int xi, input int yi, input bit go, input bit blz,
                                input int abort_at, input bit poke_plot);
      int   ndrawn, nw1_exp, nw0_exp, exp_done;
      int   cyc, done_cyc, done1_cyc, nw0, nw1, busy_cnt, done_cnt;
      bit   fin;
      pix_t p;
      exp_q.delete();
      buildModel(sc, xi, yi, go, blz, ndrawn, nw1_exp);
      nw0_exp  = exp_q.size();
      exp_done = SCORE_W + DIGITS + PIXCYC * ndrawn + 1;
      @(negedge clk);
      score = 10'(sc); x_in = 9'(xi); y_in = 8'(yi); game_over = go; blank_lz = blz; plot = 1'b1;
      @(posedge clk);
      #1;
      plot = 1'b0;
      score = 10'($urandom); x_in = 9'($urandom); y_in = 8'($urandom);
      game_over = ~go; blank_lz = ~blz;
      cyc = 0; done_cyc = 0; done1_cyc = 0; nw0 = 0; nw1 = 0; busy_cnt = 0; done_cnt = 0;
      fin = 1'b0;
      while (!fin) begin
         @(negedge clk);
         cyc++;
         if (busy0) busy_cnt++;
         if (done0) done_cnt++;
         if (we0) begin
            nw0++;
            if (exp_q.size() == 0)
               checkOutput("extra_write", {12'b0, x_out0, y_out0, colour0}, 32'hFFFFFFFF);
            else begin
               p = exp_q.pop_front();
               checkOutput("pixel", {12'b0, x_out0, y_out0, colour0}, {12'b0, p});
            end
         end
         if (we1) nw1++;
         if (done0 && done_cyc == 0) done_cyc = cyc;
         if (done1 && done1_cyc == 0) done1_cyc = cyc;
         if (!blz && abort_at == 0)
            for (int k = 0; k < DIGITS; k++)
               if (cyc == SCORE_W + 2 + k * (1 + PIXCYC))
                  checkOutput("rom_addr_first", 32'(rom_addr0), 32'(dd_exp[k] * 1024));
         plot = (poke_plot && cyc >= 100 && cyc < 104);
         if (poke_plot) x_in = 9'($urandom);
         if (abort_at != 0) begin
            if (cyc == abort_at) resetn = 1'b0;
            if (cyc == abort_at + 1) begin
               checkOutput("abort_outputs",
                           {3'b0, rom_addr0, x_out0, y_out0, colour0, we0, busy0, done0} , 32'h0);
               resetn = 1'b1;
            end
            if (cyc == abort_at + 5) begin
               checkOutput("abort_no_done", 32'(done_cyc), 32'd0);
               checkOutput("abort_idle", {30'b0, busy0, busy1}, 32'd0);
               fin = 1'b1;
            end
         end else begin
            if (done_cyc != 0 && cyc == done_cyc + 1) begin
               checkOutput("idle_after_done", {30'b0, busy0, done0}, 32'd0);
               fin = 1'b1;
            end
            if (cyc > exp_done + 20) begin
               checkOutput("timeout", 32'(cyc), 32'(exp_done));
               fin = 1'b1;
            end
         end
      end
      if (abort_at == 0) begin
         checkOutput("done_cycle", 32'(done_cyc), 32'(exp_done));
         checkOutput("done1_cycle", 32'(done1_cyc), 32'(exp_done));
         checkOutput("done_width", 32'(done_cnt), 32'd1);
         checkOutput("busy_cycles", 32'(busy_cnt), 32'(exp_done));
         checkOutput("writes0", 32'(nw0), 32'(nw0_exp));
         checkOutput("writes1", 32'(nw1), 32'(nw1_exp));
         checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
      end
   endtask

   initial begin
      resetn = 1'b0;
      repeat (3) @(negedge clk);
      checkOutput("reset_outputs",
                  {3'b0, rom_addr0, x_out0, y_out0, colour0, we0, busy0, done0}, 32'h0);
      resetn = 1'b1;
      @(negedge clk);

      applyStimulus(7,    100, 20,  1'b0, 1'b1, 0,   1'b0);
      applyStimulus(7,    100, 20,  1'b0, 1'b0, 0,   1'b0);
      applyStimulus(1023, 40,  50,  1'b1, 1'b0, 0,   1'b0);
      applyStimulus(123,  300, 0,   1'b0, 1'b0, 0,   1'b0);
      applyStimulus(900,  0,   250, 1'b0, 1'b0, 0,   1'b0);
      rom_zero = 1'b1;
      applyStimulus(5,    60,  100, 1'b1, 1'b1, 0,   1'b0);
      rom_zero = 1'b0;
      applyStimulus(7,    100, 20,  1'b0, 1'b1, 500, 1'b0);
      applyStimulus(42,   10,  5,   1'b0, 1'b1, 0,   1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
